// File: rtl/fsbm_pkg.sv
// fsbm_pkg: shared types, widths and result packing for the block-matching best-match stage
package fsbm_pkg;
  localparam int SAD_W = 16;
  localparam int MV_W = 4;
  localparam int SAD_OUT_W = 12;
  localparam int SER_LEN = 20;
  localparam int PACK_W = 2 * MV_W + SAD_OUT_W;
  typedef enum logic [1:0] {IDLE, SEARCH, LOAD, DRAIN} state_t;
  function automatic logic [PACK_W-1:0] pack(input logic [2*MV_W-1:0] mv, input logic [SAD_OUT_W-1:0] sad_sat);
    return {mv, sad_sat};
  endfunction
endpackage

// File: rtl/fsbm_min_tracker.sv
// fsbm_min_tracker: running minimum SAD and its index, with the post-update winner exposed saturated
module fsbm_min_tracker #(
  parameter int SAD_W = 16,
  parameter int IDX_W = 8,
  parameter int SAD_OUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [IDX_W-1:0]     idx,
  input  logic [SAD_W-1:0]     sad_in,
  output logic [IDX_W-1:0]     win_idx,
  output logic [SAD_OUT_W-1:0] win_sat
);
  logic [SAD_W-1:0] best_sad, win_sad;
  logic [IDX_W-1:0] best_idx;
  logic take;
  // strict less-than keeps the earliest candidate on ties
  assign take = accept && (idx == '0 || sad_in < best_sad);
  assign win_sad = take ? sad_in : best_sad;
  assign win_idx = take ? idx : best_idx;
  assign win_sat = |win_sad[SAD_W-1:SAD_OUT_W] ? '1 : win_sad[SAD_OUT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= '1;
      best_idx <= '0;
    end else if (clear) begin
      best_sad <= '1;
      best_idx <= '0;
    end else begin
      best_sad <= win_sad;
      best_idx <= win_idx;
    end
  end
endmodule

// File: rtl/fsbm_best_match.sv
// fsbm_best_match: picks the minimum-SAD candidate of a full search, packs it and loads the serializer
module fsbm_best_match #(
  parameter int SAD_W = fsbm_pkg::SAD_W,
  parameter int MV_W = fsbm_pkg::MV_W,
  parameter int SAD_OUT_W = fsbm_pkg::SAD_OUT_W,
  parameter int SER_LEN = fsbm_pkg::SER_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          sad_valid,
  input  logic [SAD_W-1:0]              sad_in,
  output logic                          sad_ready,
  output logic [2*MV_W+SAD_OUT_W-1:0]   data_raw,
  output logic                          en_input,
  output logic                          busy,
  output logic                          done
);
  import fsbm_pkg::*;
  localparam int IDX_W = 2 * MV_W;
  localparam int DC_W = $clog2(SER_LEN);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, win_idx;
  logic [SAD_OUT_W-1:0] win_sat;
  logic [DC_W-1:0] dcnt;
  logic accept, last, drain_end;
  assign accept = sad_valid && state == SEARCH;
  assign last = accept && &idx;
  assign drain_end = state == DRAIN && dcnt == DC_W'(SER_LEN - 1);
  fsbm_min_tracker #(.SAD_W(SAD_W), .IDX_W(IDX_W), .SAD_OUT_W(SAD_OUT_W)) u_min (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .accept(accept),
    .idx(idx),
    .sad_in(sad_in),
    .win_idx(win_idx),
    .win_sat(win_sat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SEARCH : IDLE;
      SEARCH:  state_nxt = last ? LOAD : SEARCH;
      LOAD:    state_nxt = DRAIN;
      DRAIN:   state_nxt = drain_end ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    sad_ready = state == SEARCH;
    en_input = state == LOAD;
    busy = state != IDLE;
    done = drain_end;
  end
  // the winner is packed from the post-update best so the final candidate counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      dcnt <= '0;
      data_raw <= '0;
    end else begin
      idx <= state == SEARCH ? idx + IDX_W'(accept) : '0;
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (last) data_raw <= pack(win_idx, win_sat);
    end
  end
endmodule
